// File: rtl/ifetch_pkg.sv
// Shared fetch-path constants: state encoding, reset vector, NOP word.
// Also used by the PC register and the main controller.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] IF_RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] IF_NOP        = 32'h0000_0000;

endpackage

// File: rtl/ifetch_timeout_ctr.sv
// Outstanding-request watchdog: clearable up-counter with terminal flag.
// Saturates at TIMEOUT-1 so tc_o stays asserted until cleared.
module ifetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: req/ack read into IR, PCWrite strobe,
// misalign / timeout / flush handling.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned         WIDTH      = 32,
    parameter logic [WIDTH-1:0]    RESET_ADDR = WIDTH'(IF_RESET_ADDR),
    parameter int unsigned         TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_addr,
    input  logic             fetch_req,
    input  logic             flush,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    output logic             pc_write,
    output logic             busy,
    output logic             addr_err,
    output logic             bus_err
);

    fetch_state_e     state_q;
    logic             mem_req_q;
    logic [WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0] instr_q;
    logic             instr_valid_q;
    logic             pc_write_q;
    logic             addr_err_q;
    logic             bus_err_q;

    logic fetch_ok;
    logic ctr_clr;
    logic ctr_en;
    logic ctr_tc;

    assign fetch_ok = fetch_req && !flush && (pc_addr[1:0] == 2'b00);
    assign ctr_clr  = (state_q == ST_IDLE) && fetch_ok;
    assign ctr_en   = (state_q != ST_IDLE) && !mem_ack;

    ifetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (ctr_clr),
        .en_i  (ctr_en),
        .tc_o  (ctr_tc)
    );

    // Strobes default low every cycle so they can only ever pulse once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= RESET_ADDR;
            instr_q       <= WIDTH'(IF_NOP);
            instr_valid_q <= 1'b0;
            pc_write_q    <= 1'b0;
            addr_err_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            pc_write_q <= 1'b0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        instr_valid_q <= 1'b0;
                    end else if (fetch_req) begin
                        if (pc_addr[1:0] != 2'b00) begin
                            addr_err_q <= 1'b1;
                        end else begin
                            mem_addr_q    <= pc_addr;
                            mem_req_q     <= 1'b1;
                            instr_valid_q <= 1'b0;
                            state_q       <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        if (flush) begin
                            instr_valid_q <= 1'b0;
                        end else begin
                            instr_q       <= mem_rdata;
                            instr_valid_q <= 1'b1;
                            pc_write_q    <= 1'b1;
                        end
                    end else if (ctr_tc) begin
                        bus_err_q     <= 1'b1;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else if (flush) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (ctr_tc) begin
                        bus_err_q     <= 1'b1;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_write    = pc_write_q;
    assign addr_err    = addr_err_q;
    assign bus_err     = bus_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, fetch, misalign, flush,
// timeout, async reset and back-to-back fetch.
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_addr;
    logic        fetch_req;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        pc_write;
    logic        busy;
    logic        addr_err;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    ifetch_unit #(
        .WIDTH      (32),
        .RESET_ADDR (32'h0000_3000),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_addr     (pc_addr),
        .fetch_req   (fetch_req),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_write    (pc_write),
        .busy        (busy),
        .addr_err    (addr_err),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        pc_addr   = 32'h0;
        fetch_req = 1'b0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (mem_addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL reset_addr got %h exp %h", mem_addr, 32'h3000);
        end
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_req got %b/%b exp 0/0", mem_req, busy);
        end
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ir got %h/%b exp 0/0", instr, instr_valid);
        end
        checks++;
        if ({pc_write, addr_err, bus_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 000",
                     {pc_write, addr_err, bus_err});
        end
    endtask

    task automatic test_basic_fetch();
        int hi = 0;
        int bad_addr = 0;
        pc_addr   = 32'h0000_3000;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (mem_req === 1'b1) hi++;
            if (mem_addr !== 32'h0000_3000) bad_addr++;
            if (i == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h2008_0005;
            end else begin
                tick();
            end
        end
        tick();
        mem_ack = 1'b0;
        checks++;
        if (hi != 3 || bad_addr != 0) begin
            errors++;
            $display("FAIL basic_req got hi=%0d badaddr=%0d exp 3/0",
                     hi, bad_addr);
        end
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_drop got %b/%b exp 0/0", mem_req, busy);
        end
        checks++;
        if (instr !== 32'h2008_0005 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_ir got %h/%b exp 20080005/1",
                     instr, instr_valid);
        end
        checks++;
        if (pc_write !== 1'b1) begin
            errors++;
            $display("FAIL basic_pcw got %b exp 1", pc_write);
        end
        tick();
        checks++;
        if (pc_write !== 1'b0 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_pcw_pulse got %b/%b exp 0/1",
                     pc_write, instr_valid);
        end
    endtask

    task automatic test_misaligned();
        pc_addr   = 32'h0000_3002;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (addr_err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mis_err got %b/%b/%b exp 1/0/0",
                     addr_err, mem_req, busy);
        end
        checks++;
        if (instr !== 32'h2008_0005 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL mis_ir got %h/%b exp 20080005/1",
                     instr, instr_valid);
        end
        tick();
        checks++;
        if (addr_err !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse got %b/%b exp 0/0", addr_err, mem_req);
        end
    endtask

    task automatic test_flush_wait();
        pc_addr   = 32'h0000_3004;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3004) begin
            errors++;
            $display("FAIL fl_start got %b/%h exp 1/00003004",
                     mem_req, mem_addr);
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (dut.state_q !== 2'd2 || busy !== 1'b1 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL fl_drop got st=%0d busy=%b req=%b exp 2/1/1",
                     dut.state_q, busy, mem_req);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || pc_write !== 1'b0) begin
            errors++;
            $display("FAIL fl_end got %b/%b/%b exp 0/0/0",
                     mem_req, busy, pc_write);
        end
        checks++;
        if (instr !== 32'h2008_0005 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fl_ir got %h/%b exp 20080005/0",
                     instr, instr_valid);
        end
    endtask

    task automatic test_timeout();
        int seen = -1;
        int drops = 0;
        pc_addr   = 32'h0000_300C;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus_err === 1'b1) begin
                seen = i;
                break;
            end
            if (mem_req !== 1'b1) drops++;
        end
        checks++;
        if (seen != 16 || drops != 0) begin
            errors++;
            $display("FAIL to_cycle got %0d drops=%0d exp 16/0", seen, drops);
        end
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || pc_write !== 1'b0) begin
            errors++;
            $display("FAIL to_state got %b/%b/%b exp 0/0/0",
                     mem_req, busy, pc_write);
        end
        tick();
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse got %b exp 0", bus_err);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (pc_write !== 1'b0 || instr !== 32'h2008_0005 ||
            instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL to_late_ack got %b/%h/%b/%b exp 0/20080005/0/0",
                     pc_write, instr, instr_valid, mem_req);
        end
    endtask

    task automatic test_async_reset();
        pc_addr   = 32'h0000_3010;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h3000) begin
            errors++;
            $display("FAIL ar_now got %b/%b/%h exp 0/0/00003000",
                     mem_req, busy, mem_addr);
        end
        tick();
        rst = 1'b1;
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_ir got %h/%b exp 0/0", instr, instr_valid);
        end
        pc_addr   = 32'h0000_3008;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3008) begin
            errors++;
            $display("FAIL ar_refetch got %b/%h exp 1/00003008",
                     mem_req, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h8C08_0004;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (instr !== 32'h8C08_0004 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL ar_done got %h/%b exp 8c080004/1", instr, pc_write);
        end
    endtask

    task automatic test_back_to_back();
        pc_addr   = 32'h0000_300C;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_300C ||
            pc_write !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start got %b/%h/%b/%b exp 1/0000300c/0/0",
                     mem_req, mem_addr, pc_write, instr_valid);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0109_5020;
        pc_addr   = 32'h0000_3010;
        fetch_req = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (instr !== 32'h0109_5020 || pc_write !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got %h/%b/%b exp 01095020/1/0",
                     instr, pc_write, busy);
        end
        tick();
        fetch_req = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3010 ||
            pc_write !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got %b/%h/%b exp 1/00003010/0",
                     mem_req, mem_addr, pc_write);
        end
        flush = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        flush = 1'b0;
        mem_ack = 1'b0;
        checks++;
        if (pc_write !== 1'b0 || instr !== 32'h0109_5020 ||
            instr_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ackflush got %b/%h/%b/%b exp 0/01095020/0/0",
                     pc_write, instr, instr_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_misaligned();
        test_flush_wait();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
